// File: rtl/instr_encoder.sv
// instr_encoder: sequential RV32I instruction encoder.
// Takes decoded field requests over a valid/ready handshake, range-checks the
// immediate, scatters it into the format's bit positions and streams the
// resulting words into the instruction-memory load port at auto-incrementing
// word addresses. Illegal requests are consumed and counted, never written.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    fmt,
    input  logic [6:0]    opcode,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          err,
    output logic [7:0]    err_cnt,
    output logic [15:0]   word_cnt
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_R = 3'b100;

    localparam logic [AW-1:0] START_ADDR = AW'(BASE_ADDR);
    localparam logic [AW-1:0] ADDR_STEP  = AW'(32'd4);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // True when the upper immediate bits are a pure sign extension of
    // bit `msb`, i.e. the value fits the signed field the format carries.
    function automatic logic imm_legal(input logic [2:0] f, input logic [31:0] v);
        logic ok;
        case (f)
            FMT_I, FMT_S: ok = (&v[31:11]) || !(|v[31:11]);
            FMT_B:        ok = ((&v[31:12]) || !(|v[31:12])) && (v[0] == 1'b0);
            FMT_J:        ok = ((&v[31:20]) || !(|v[31:20])) && (v[0] == 1'b0);
            FMT_R:        ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Scatter the request fields into the 32-bit RV32I instruction word.
    function automatic logic [31:0] encode(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] v
    );
        logic [31:0] w;
        case (f)
            FMT_I:   w = {v[11:0], s1, f3, d, op};
            FMT_S:   w = {v[11:5], s2, s1, f3, v[4:0], op};
            FMT_B:   w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
            FMT_J:   w = {v[20], v[10:1], v[11], v[19:12], d, op};
            FMT_R:   w = {f7, s2, s1, f3, d, op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_t          state_r;
    logic [31:0]     wdata_r;
    logic [AW-1:0]   addr_r;
    logic            err_r;
    logic [7:0]      err_cnt_r;
    logic [15:0]     word_cnt_r;

    logic            full_s;
    logic            ready_s;
    logic            accept_s;
    logic            fire_s;
    logic            legal_s;
    logic [31:0]     word_s;

    assign full_s   = (state_r == ST_FULL);
    assign ready_s  = !clear && (!full_s || imem_ready);
    assign accept_s = in_valid && ready_s;
    assign fire_s   = full_s && imem_ready;
    assign legal_s  = imm_legal(fmt, imm);
    assign word_s   = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);

    assign in_ready   = ready_s;
    assign imem_we    = full_s;
    assign imem_wdata = wdata_r;
    assign imem_addr  = addr_r;
    assign err        = err_r;
    assign err_cnt    = err_cnt_r;
    assign word_cnt   = word_cnt_r;

    // Output-register FSM: load encoded words, retire them on write fire,
    // advance address/count and track rejected requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            wdata_r    <= 32'd0;
            addr_r     <= START_ADDR;
            err_r      <= 1'b0;
            err_cnt_r  <= 8'd0;
            word_cnt_r <= 16'd0;
        end else if (clear) begin
            state_r    <= ST_EMPTY;
            wdata_r    <= 32'd0;
            addr_r     <= START_ADDR;
            err_r      <= 1'b0;
            err_cnt_r  <= 8'd0;
            word_cnt_r <= 16'd0;
        end else begin
            if (fire_s) begin
                addr_r     <= addr_r + ADDR_STEP;
                word_cnt_r <= word_cnt_r + 16'd1;
            end else begin
                addr_r     <= addr_r;
                word_cnt_r <= word_cnt_r;
            end

            case (state_r)
                ST_EMPTY: begin
                    if (accept_s && legal_s) begin
                        wdata_r <= word_s;
                        state_r <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // A new word may only arrive in the same cycle the old
                    // one leaves, since in_ready is low while stalled.
                    if (accept_s && legal_s) begin
                        wdata_r <= word_s;
                        state_r <= ST_FULL;
                    end else if (fire_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase

            if (accept_s && !legal_s) begin
                err_r <= 1'b1;
                if (err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                err_r     <= err_r;
                err_cnt_r <= err_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan cases plus a
// randomized phase, all compared against a field-level reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        imem_ready;

    logic        in_ready0, imem_we0, err0;
    logic [31:0] imem_addr0, imem_wdata0;
    logic [7:0]  err_cnt0;
    logic [15:0] word_cnt0;

    logic        in_ready1, imem_we1, err1;
    logic [31:0] imem_addr1, imem_wdata1;
    logic [7:0]  err_cnt1;
    logic [15:0] word_cnt1;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] pend[$];
    logic [31:0] m_addr;
    logic [15:0] m_wc;
    int          m_ec;
    bit          m_err;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .AW(32)) dut0 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(imem_we0), .imem_ready(imem_ready),
        .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
        .err(err0), .err_cnt(err_cnt0), .word_cnt(word_cnt0)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC), .AW(32)) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(imem_we1), .imem_ready(imem_ready),
        .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
        .err(err1), .err_cnt(err_cnt1), .word_cnt(word_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Immediate legality as signed ranges and alignment.
    function automatic bit m_legal(input logic [2:0] f, input logic [31:0] v);
        int s;
        s = int'(v);
        case (f)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2:       return (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
            3'd3:       return (s >= -1048576) && (s <= 1048575) && ((s % 2) == 0);
            3'd4:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // Instruction word assembled with shifts and masks from the field layout.
    function automatic logic [31:0] m_encode(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] v);
        logic [31:0] w;
        w = 32'(op);
        case (f)
            3'd0: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | ((v & 32'hFFF) << 20);
            3'd1: w = w | ((v & 32'h1F) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                        | (32'(s2) << 20) | (((v >> 5) & 32'h7F) << 25);
            3'd2: w = w | (((v >> 11) & 32'h1) << 7) | (((v >> 1) & 32'hF) << 8)
                        | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                        | (((v >> 5) & 32'h3F) << 25) | (((v >> 12) & 32'h1) << 31);
            3'd3: w = w | (32'(d) << 7) | (((v >> 12) & 32'hFF) << 12) | (((v >> 11) & 32'h1) << 20)
                        | (((v >> 1) & 32'h3FF) << 21) | (((v >> 20) & 32'h1) << 31);
            default: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                        | (32'(s2) << 20) | (32'(f7) << 25);
        endcase
        return w;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_addr = 32'd0;
        m_wc   = 16'd0;
        m_ec   = 0;
        m_err  = 1'b0;
    endtask

    // Compare DUT outputs with the model, then advance the model by one edge.
    task automatic model_step();
        bit full, rdy, fire, acc;
        full = (pend.size() != 0);
        rdy  = !clear && (!full || imem_ready);
        chk("in_ready", 32'(in_ready0), 32'(rdy));
        chk("in_ready1", 32'(in_ready1), 32'(rdy));
        chk("we", 32'(imem_we0), 32'(full));
        chk("we1", 32'(imem_we1), 32'(full));
        if (full) begin
            chk("wdata", imem_wdata0, pend[0]);
            chk("wdata1", imem_wdata1, pend[0]);
        end
        chk("addr", imem_addr0, m_addr);
        chk("addr1", imem_addr1, m_addr + 32'hFFFF_FFFC);
        chk("err", 32'(err0), 32'(m_err));
        chk("err_cnt", 32'(err_cnt0), 32'(m_ec));
        chk("word_cnt", 32'(word_cnt0), 32'(m_wc));
        if (clear) begin
            model_reset();
        end else begin
            fire = full && imem_ready;
            acc  = in_valid && rdy;
            if (fire) begin
                m_addr = m_addr + 32'd4;
                m_wc   = m_wc + 16'd1;
                void'(pend.pop_front());
            end
            if (acc) begin
                if (m_legal(fmt, imm)) begin
                    pend.push_back(m_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
                end else begin
                    m_err = 1'b1;
                    if (m_ec < 255) m_ec = m_ec + 1;
                end
            end
        end
    endtask

    task automatic cycle();
        #3;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] v);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = v; in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(imem_we0), 32'd0);
        chk({tag, "_we1"}, 32'(imem_we1), 32'd0);
        chk({tag, "_wdata"}, imem_wdata0, 32'd0);
        chk({tag, "_addr"}, imem_addr0, 32'h0000_0000);
        chk({tag, "_addr1"}, imem_addr1, 32'hFFFF_FFFC);
        chk({tag, "_err"}, 32'(err0), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt0), 32'd0);
        chk({tag, "_word_cnt"}, 32'(word_cnt1), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready0), 32'd1);
    endtask

    int imm_edges[13] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                          1048574, 1048576, -1048576, -1048578, -2};

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
        model_reset();
        #2;
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // I-type
        req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        cycle();
        chk("i_data", imem_wdata0, 32'hFFF0_0093);
        chk("i_addr", imem_addr0, 32'h0);
        idle();
        cycle();
        chk("i_wcnt", 32'(word_cnt0), 32'd1);

        // clear, then S and B back-to-back
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        req(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        cycle();
        chk("s_data", imem_wdata0, 32'h0020_A423);
        chk("s_addr", imem_addr0, 32'h0);
        req(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        cycle();
        chk("b_data", imem_wdata0, 32'hFE00_0EE3);
        chk("b_addr", imem_addr0, 32'h4);
        chk("b_we", 32'(imem_we0), 32'd1);
        idle();
        cycle();
        chk("sb_wcnt", 32'(word_cnt0), 32'd2);

        // J with three cycles of backpressure
        req(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        cycle();
        chk("j_data", imem_wdata0, 32'h0010_00EF);
        idle();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("j_hold_data", imem_wdata0, 32'h0010_00EF);
            chk("j_hold_rdy", 32'(in_ready0), 32'd0);
        end
        imem_ready = 1'b1;
        cycle();
        chk("j_fire_we", 32'(imem_we0), 32'd0);
        chk("j_wcnt", 32'(word_cnt0), 32'd3);

        // illegal requests
        req(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        cycle();
        req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        cycle();
        req(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        cycle();
        idle();
        cycle();
        chk("ill_err", 32'(err0), 32'd1);
        chk("ill_cnt", 32'(err_cnt0), 32'd3);
        chk("ill_we", 32'(imem_we0), 32'd0);
        req(3'd4, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
        cycle();
        chk("ill_next_we", 32'(imem_we0), 32'd1);
        idle();
        cycle();

        // clear while FULL with a pending request
        req(3'd4, 7'h33, 5'd6, 5'd7, 5'd8, 3'd7, 7'h00, 32'd0);
        cycle();
        req(3'd0, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        clear = 1'b1;
        cycle();
        chk("clr_we", 32'(imem_we0), 32'd0);
        chk("clr_addr", imem_addr0, 32'h0);
        chk("clr_wcnt", 32'(word_cnt0), 32'd0);
        chk("clr_ecnt", 32'(err_cnt0), 32'd0);
        idle();
        cycle();

        // async reset mid-stream, then address wrap on the high-base instance
        req(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        cycle();
        idle();
        #1 reset = 1'b1;
        #1 check_reset_vals("arst");
        reset = 1'b0;
        model_reset();
        req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
        cycle();
        chk("wrap_a1", imem_addr1, 32'hFFFF_FFFC);
        req(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd20);
        cycle();
        chk("wrap_a2", imem_addr1, 32'h0000_0000);
        chk("wrap_a2_base0", imem_addr0, 32'h4);
        idle();
        cycle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] v;
            case ($urandom % 4)
                0:       v = $urandom;
                1:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                default: v = 32'(imm_edges[$urandom % 13]);
            endcase
            req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), v);
            in_valid   = ($urandom % 4) != 0;
            imem_ready = ($urandom % 4) != 0;
            clear      = ($urandom % 40) == 0;
            cycle();
        end
        idle();
        imem_ready = 1'b1;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
